// File: rtl/dmem_arb_pkg.sv
// Shared types, funct3 codes and access-legality check for the data-memory arbiter.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package dmem_arb_pkg;

   localparam int N_REQ = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } dmem_arb_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;

   // Loads accept B/H/W/BU, stores accept B/H/W; halves and words must be naturally aligned.
   function automatic logic dmem_access_legal(input logic       write,
                                              input logic [2:0] funct3,
                                              input logic [1:0] addr_lo);
      logic ok;
      ok = 1'b0;
      case (funct3)
         F3_B:    ok = 1'b1;
         F3_H:    ok = ~addr_lo[0];
         F3_W:    ok = (addr_lo == 2'b00);
         F3_BU:   ok = ~write;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side handshake bus plus memory control/data bus of the data-memory arbiter.
// Latency: none (wires only).
// Backpressure: req_ready grants one requester per transaction; responses cannot be stalled.
interface dmem_arbiter_if #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
) ();
   import dmem_arb_pkg::*;

   logic [N_REQ-1:0]                 req_valid;
   logic [N_REQ-1:0]                 req_ready;
   logic [N_REQ-1:0]                 req_write;
   logic [N_REQ-1:0][DM_ADDRESS-1:0] req_addr;
   logic [N_REQ-1:0][DATA_W-1:0]     req_wdata;
   logic [N_REQ-1:0][2:0]            req_funct3;

   logic [N_REQ-1:0]                 resp_valid;
   logic                             resp_err;
   logic [DATA_W-1:0]                resp_rdata;

   logic                             mem_read;
   logic                             mem_write;
   logic [DM_ADDRESS-1:0]            mem_addr;
   logic [DATA_W-1:0]                mem_wd;
   logic [2:0]                       mem_funct3;
   logic [DATA_W-1:0]                mem_rd;

   // Arbiter view.
   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_funct3, mem_rd,
      output req_ready, resp_valid, resp_err, resp_rdata,
             mem_read, mem_write, mem_addr, mem_wd, mem_funct3
   );

   // Requester and memory view.
   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_funct3, mem_rd,
      input  req_ready, resp_valid, resp_err, resp_rdata,
             mem_read, mem_write, mem_addr, mem_wd, mem_funct3
   );

endinterface

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin pick: one-hot grant from the request strobes and the last winner.
// Latency: combinational.
// Backpressure: a losing requester simply sees no grant and keeps its request up.
module dmem_rr_pick (
   input  logic [1:0] req_valid,
   input  logic       last,
   output logic [1:0] grant
);

   // On a tie the requester that did not win last time is favoured.
   always_comb begin
      grant = 2'b00;
      case (req_valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the LSU (req 0) and DMA (req 1), rejecting illegal accesses.
// Latency: legal access accepted T, memory T+1, response T+2; illegal access responds at T+1.
// Backpressure: req_ready only in IDLE, one requester at a time; responses are strobes with no stall.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
) (
   input logic           clk,
   input logic           reset_n,
   dmem_arbiter_if.slave bus
);

   dmem_arb_state_e       state_q, state_d;
   logic [1:0]            pick;
   logic                  win;
   logic                  accept;
   logic                  legal;

   logic [1:0]            grant_q;
   logic                  last_q;
   logic                  write_q;
   logic [DM_ADDRESS-1:0] addr_q;
   logic [DATA_W-1:0]     wdata_q;
   logic [2:0]            funct3_q;
   logic [DATA_W-1:0]     rdata_q;
   logic                  err_q;

   dmem_rr_pick u_pick (
      .req_valid (bus.req_valid),
      .last      (last_q),
      .grant     (pick)
   );

   assign win    = pick[1];
   assign accept = (state_q == IDLE) && (bus.req_valid != '0);
   assign legal  = dmem_access_legal(bus.req_write[win], bus.req_funct3[win],
                                     bus.req_addr[win][1:0]);

   // State register; reset drops any in-flight access or response.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next state and outputs; memory/response outputs are decoded only from registers.
   always_comb begin
      state_d        = state_q;
      bus.req_ready  = '0;
      bus.resp_valid = '0;
      bus.resp_err   = 1'b0;
      bus.resp_rdata = '0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.mem_addr   = '0;
      bus.mem_wd     = '0;
      bus.mem_funct3 = '0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               bus.req_ready = pick;
               state_d       = legal ? ACCESS : RESP;
            end
         end
         ACCESS: begin
            bus.mem_read   = ~write_q;
            bus.mem_write  = write_q;
            bus.mem_addr   = addr_q;
            bus.mem_wd     = wdata_q;
            bus.mem_funct3 = funct3_q;
            state_d        = RESP;
         end
         RESP: begin
            bus.resp_valid = grant_q;
            bus.resp_err   = err_q;
            bus.resp_rdata = rdata_q;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Request latch on acceptance, read-data capture as ACCESS ends.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         grant_q  <= '0;
         last_q   <= 1'b1;
         write_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         funct3_q <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         if (accept) begin
            grant_q  <= pick;
            last_q   <= win;
            write_q  <= bus.req_write[win];
            addr_q   <= bus.req_addr[win];
            wdata_q  <= bus.req_wdata[win];
            funct3_q <= bus.req_funct3[win];
            err_q    <= ~legal;
            rdata_q  <= '0;
         end
         if (state_q == ACCESS) begin
            rdata_q <= write_q ? '0 : bus.mem_rd;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed requests, expected responses and memory accesses queued at issue.
// Latency: checks response cycle T+2 (legal) / T+1 (error) and memory access cycle T+1.
// Backpressure: requesters wait for req_ready with a bounded cycle budget.
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   int   cyc     = 0;
   int   total   = 0;
   int   bad     = 0;

   dmem_arbiter_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();

   dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   // Cycle index; a cycle starts at its rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [1:0]  grant;
      logic        err;
      logic [31:0] rdata;
      int          t;
   } resp_t;

   typedef struct {
      logic        wr;
      logic [8:0]  addr;
      logic [31:0] wd;
      logic [2:0]  f3;
      int          t;
   } acc_t;

   resp_t rq[$];
   acc_t  aq[$];

   // Byte-addressed memory, writes on the falling edge.
   logic [7:0] mem [0:511];
   logic [8:0] wa1, wa2, wa3;
   assign wa1 = bus.mem_addr + 9'd1;
   assign wa2 = bus.mem_addr + 9'd2;
   assign wa3 = bus.mem_addr + 9'd3;

   always @(negedge clk) begin
      if (bus.mem_write) begin
         mem[bus.mem_addr] <= bus.mem_wd[7:0];
         if (bus.mem_funct3 == F3_H || bus.mem_funct3 == F3_W) mem[wa1] <= bus.mem_wd[15:8];
         if (bus.mem_funct3 == F3_W) begin
            mem[wa2] <= bus.mem_wd[23:16];
            mem[wa3] <= bus.mem_wd[31:24];
         end
      end
   end

   // Combinational extended read.
   always_comb begin
      bus.mem_rd = 32'h0;
      case (bus.mem_funct3)
         F3_B:  bus.mem_rd = {{24{mem[bus.mem_addr][7]}}, mem[bus.mem_addr]};
         F3_H:  bus.mem_rd = {{16{mem[wa1][7]}}, mem[wa1], mem[bus.mem_addr]};
         F3_W:  bus.mem_rd = {mem[wa3], mem[wa2], mem[wa1], mem[bus.mem_addr]};
         F3_BU: bus.mem_rd = {24'h0, mem[bus.mem_addr]};
         default: bus.mem_rd = 32'h0;
      endcase
   end

   // Monitor: pops expectations whenever the DUT presents a response or a memory access.
   always @(negedge clk) begin : mon
      resp_t e;
      acc_t  m;
      total++;
      if (bus.req_ready == 2'b11) begin
         bad++;
         $display("FAIL ready_onehot: got %b want at most one bit", bus.req_ready);
      end
      if (bus.resp_valid != 2'b00) begin
         total++;
         if (rq.size() == 0) begin
            bad++;
            $display("FAIL resp_unexpected: got v=%b e=%b d=%h at %0d, want none",
                     bus.resp_valid, bus.resp_err, bus.resp_rdata, cyc);
         end else begin
            e = rq.pop_front();
            if (bus.resp_valid !== e.grant || bus.resp_err !== e.err ||
                bus.resp_rdata !== e.rdata || cyc != e.t) begin
               bad++;
               $display("FAIL resp: got v=%b e=%b d=%h at %0d, want v=%b e=%b d=%h at %0d",
                        bus.resp_valid, bus.resp_err, bus.resp_rdata, cyc,
                        e.grant, e.err, e.rdata, e.t);
            end
         end
      end
      total++;
      if (bus.mem_read || bus.mem_write) begin
         if (aq.size() == 0 || (bus.mem_read && bus.mem_write)) begin
            bad++;
            $display("FAIL mem_unexpected: got r=%b w=%b a=%h at %0d, want no access",
                     bus.mem_read, bus.mem_write, bus.mem_addr, cyc);
         end else begin
            m = aq.pop_front();
            if (bus.mem_write !== m.wr || bus.mem_read !== ~m.wr || bus.mem_addr !== m.addr ||
                bus.mem_wd !== m.wd || bus.mem_funct3 !== m.f3 || cyc != m.t) begin
               bad++;
               $display("FAIL mem_access: got w=%b a=%h wd=%h f3=%b at %0d, want w=%b a=%h wd=%h f3=%b at %0d",
                        bus.mem_write, bus.mem_addr, bus.mem_wd, bus.mem_funct3, cyc,
                        m.wr, m.addr, m.wd, m.f3, m.t);
            end
         end
      end else if (bus.mem_addr != 9'h0 || bus.mem_wd != 32'h0 || bus.mem_funct3 != 3'b0) begin
         bad++;
         $display("FAIL mem_idle: got a=%h wd=%h f3=%b, want all 0",
                  bus.mem_addr, bus.mem_wd, bus.mem_funct3);
      end
   end

   task automatic expect_txn(input int r, input logic wr, input logic [8:0] addr,
                             input logic [31:0] wd, input logic [2:0] f3,
                             input logic err, input logic [31:0] rd, input int t);
      resp_t e;
      acc_t  m;
      e.grant = 2'b01 << r;
      e.err   = err;
      e.rdata = rd;
      e.t     = err ? t + 1 : t + 2;
      rq.push_back(e);
      if (!err) begin
         m.wr = wr; m.addr = addr; m.wd = wd; m.f3 = f3; m.t = t + 1;
         aq.push_back(m);
      end
   endtask

   task automatic wait_any(output logic [1:0] g, output bit ok);
      ok = 1'b0;
      g  = 2'b00;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.req_ready != 2'b00) begin
            g  = bus.req_ready;
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL grant_timeout: got no req_ready, want a grant");
      end
   endtask

   task automatic set_req(input int r, input logic wr, input logic [8:0] addr,
                          input logic [31:0] wd, input logic [2:0] f3);
      bus.req_write[r]  = wr;
      bus.req_addr[r]   = addr;
      bus.req_wdata[r]  = wd;
      bus.req_funct3[r] = f3;
      bus.req_valid[r]  = 1'b1;
   endtask

   // One request from requester r; abort=1 pulls reset during its ACCESS cycle.
   task automatic issue(input int r, input logic wr, input logic [8:0] addr,
                        input logic [31:0] wd, input logic [2:0] f3,
                        input logic err, input logic [31:0] rd, input bit abort);
      logic [1:0] g;
      bit         ok;
      logic [1:0] want;
      want = 2'b01 << r;
      set_req(r, wr, addr, wd, f3);
      wait_any(g, ok);
      if (ok) begin
         total++;
         if (g !== want) begin
            bad++;
            $display("FAIL grant_single: got %b want %b", g, want);
         end
         if (!abort) expect_txn(r, wr, addr, wd, f3, err, rd, cyc);
      end
      @(posedge clk);
      #1;
      if (abort) begin
         reset_n = 1'b0;
         bus.req_valid[r] = 1'b0;
         #1;
         total++;
         if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_read, bus.mem_write} != 7'b0 ||
             bus.mem_addr != 9'h0 || bus.mem_wd != 32'h0) begin
            bad++;
            $display("FAIL abort_clear: got rd=%b wr=%b rv=%b, want all 0",
                     bus.mem_read, bus.mem_write, bus.resp_valid);
         end
         @(negedge clk);
         @(posedge clk);
         #1;
         reset_n = 1'b1;
      end else begin
         bus.req_valid[r] = 1'b0;
      end
   endtask

   // Both requesters hold word loads up; grants must alternate starting at 'first'.
   task automatic contend(input int first, input int n);
      logic [1:0] g;
      logic [1:0] want;
      bit         ok;
      int         ex;
      ex = first;
      set_req(0, 1'b0, 9'h010, 32'h0, F3_W);
      set_req(1, 1'b0, 9'h020, 32'h0, F3_W);
      for (int k = 0; k < n; k++) begin
         wait_any(g, ok);
         if (!ok) break;
         want = 2'b01 << ex;
         total++;
         if (g !== want) begin
            bad++;
            $display("FAIL grant_rr%0d: got %b want %b", k, g, want);
         end
         expect_txn(ex, 1'b0, (ex == 0) ? 9'h010 : 9'h020, 32'h0, F3_W, 1'b0,
                    (ex == 0) ? 32'h80ADBEEF : 32'hCAFEF00D, cyc);
         ex = 1 - ex;
      end
      @(posedge clk);
      #1;
      bus.req_valid = 2'b00;
   endtask

   // req1 pulses valid while req0 is in ACCESS and must leave no trace.
   task automatic withdraw();
      logic [1:0] g;
      bit         ok;
      set_req(0, 1'b0, 9'h010, 32'h0, F3_W);
      wait_any(g, ok);
      if (ok) expect_txn(0, 1'b0, 9'h010, 32'h0, F3_W, 1'b0, 32'h80ADBEEF, cyc);
      @(posedge clk);
      #1;
      bus.req_valid[0] = 1'b0;
      set_req(1, 1'b0, 9'h020, 32'h0, F3_W);
      @(negedge clk);
      total++;
      if (bus.req_ready !== 2'b00) begin
         bad++;
         $display("FAIL withdraw_ready: got %b want 00", bus.req_ready);
      end
      @(posedge clk);
      #1;
      bus.req_valid[1] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      bus.req_valid  = '0;
      bus.req_write  = '0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.req_funct3 = '0;
      repeat (2) @(negedge clk);
      total++;
      if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_read, bus.mem_write} != 7'b0 ||
          bus.resp_rdata != 32'h0 || bus.mem_addr != 9'h0 || bus.mem_wd != 32'h0 ||
          bus.mem_funct3 != 3'b0) begin
         bad++;
         $display("FAIL reset_state: got rv=%b err=%b rd=%h, want all 0",
                  bus.resp_valid, bus.resp_err, bus.resp_rdata);
      end
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Word store then load.
      issue(0, 1'b1, 9'h010, 32'hDEADBEEF, F3_W, 1'b0, 32'h0, 1'b0);
      issue(0, 1'b0, 9'h010, 32'h0, F3_W, 1'b0, 32'hDEADBEEF, 1'b0);
      // Byte store and signed/unsigned byte loads from the DMA side.
      issue(1, 1'b1, 9'h013, 32'h00000080, F3_B, 1'b0, 32'h0, 1'b0);
      issue(1, 1'b0, 9'h013, 32'h0, F3_B, 1'b0, 32'hFFFFFF80, 1'b0);
      issue(1, 1'b0, 9'h013, 32'h0, F3_BU, 1'b0, 32'h00000080, 1'b0);
      issue(0, 1'b0, 9'h012, 32'h0, F3_H, 1'b0, 32'hFFFF80AD, 1'b0);
      // Illegal accesses.
      issue(0, 1'b0, 9'h002, 32'h0, F3_W, 1'b1, 32'h0, 1'b0);
      issue(0, 1'b1, 9'h005, 32'h00001234, F3_H, 1'b1, 32'h0, 1'b0);
      issue(1, 1'b0, 9'h000, 32'h0, 3'b101, 1'b1, 32'h0, 1'b0);
      issue(0, 1'b1, 9'h008, 32'h55, F3_BU, 1'b1, 32'h0, 1'b0);
      // Contents for 0x020, then withdrawal (last winner stays req0, so req1 wins the tie).
      issue(0, 1'b1, 9'h020, 32'hCAFEF00D, F3_W, 1'b0, 32'h0, 1'b0);
      withdraw();
      contend(1, 2);
      // Store aborted by reset, then fresh round-robin and readback of old data.
      issue(0, 1'b1, 9'h020, 32'h12345678, F3_W, 1'b0, 32'h0, 1'b1);
      contend(0, 4);
      issue(0, 1'b0, 9'h020, 32'h0, F3_W, 1'b0, 32'hCAFEF00D, 1'b0);

      repeat (5) @(posedge clk);
      #1;
      total++;
      if (rq.size() != 0 || aq.size() != 0) begin
         bad++;
         $display("FAIL drain: got resp_left=%0d acc_left=%0d want 0 and 0", rq.size(), aq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer that shares the single-ported data memory between the core's load/store unit (requester 0) and a DMA/debug master (requester 1). Accepts one request per transaction through a valid/ready handshake, drives the memory's `MemRead`/`MemWrite`/`a`/`wd`/`Funct3` controls for exactly one cycle, and returns the read data with a one-cycle response strobe. Misaligned or unsupported accesses are rejected with an error response and never reach the memory. Sits between the requesters and `datamemory`.

## Interface
- `DM_ADDRESS`, 9: byte-address width of the memory.
- `DATA_W`, 32: data width.
- `clk` input 1: clock. Memory writes commit on the falling edge.
- `reset_n` input 1: asynchronous active-low reset.
- `req_valid` input 2: per-requester request strobe. Index 0 = LSU, 1 = DMA.
- `req_ready` output 2: one-hot grant/accept.
- `req_write` input 2: 1 = store, 0 = load.
- `req_addr` input 2×DM_ADDRESS: byte addresses.
- `req_wdata` input 2×DATA_W: store data.
- `req_funct3` input 2×3: RISC-V width code.
- `resp_valid` output 2: one-hot, one-cycle completion strobe.
- `resp_err` output 1: qualifies `resp_valid`. 1 = misaligned or unsupported access.
- `resp_rdata` output DATA_W: load result, already extended by the memory. 0 for stores and errors.
- `mem_read`, `mem_write` output 1 each: memory controls.
- `mem_addr` output DM_ADDRESS.
- `mem_wd` output DATA_W.
- `mem_funct3` output 3.
- `mem_rd` input DATA_W: combinational read data from the memory.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - If any `req_valid` is high: pick a winner, assert its `req_ready` combinationally for that cycle, and latch its write, addr, wdata and funct3.
  - If the request is legal, go to ACCESS. Otherwise set `err_q`=1 and go directly to RESP.
- **Arbitration**
  - Round-robin using `last_q`, which resets to 1 so requester 0 wins the first tie.
  - Single valid: that requester wins.
  - Both valid: the requester ≠ `last_q` wins. `last_q` updates on every grant.
- **Legality**
  - Load funct3 must be one of 000, 001, 010, 100.
  - Store funct3 must be one of 000, 001, 010.
  - funct3 001 requires addr[0]=0.
  - funct3 010 requires addr[1:0]=00.
  - Any other combination is an error.
- **ACCESS** (exactly one cycle)
  - `mem_read`=~write, `mem_write`=write; `mem_addr`/`mem_wd`/`mem_funct3` come from the latched request.
  - `mem_rd` is captured into `rdata_q` at the rising edge that leaves ACCESS. Stores capture 0.
  - Next state is RESP.
- **RESP**
  - `resp_valid[grant_q]`=1 with `resp_err`=`err_q` and `resp_rdata`=`rdata_q`. No backpressure.
  - Next state is IDLE.
- Requesters must hold all request fields stable while `req_valid` is high and `req_ready` is low. A deasserted `req_valid` withdraws the request without effect.
- Outside ACCESS, `mem_read`/`mem_write` are 0, and `mem_addr`/`mem_wd`/`mem_funct3` are 0.

## Timing
- Reset values:
  - State IDLE, `last_q`=1.
  - `req_ready`=00, `resp_valid`=00, `resp_err`=0.
  - `resp_rdata`=0, all `mem_*` outputs 0.
- Latency for a legal access: request accepted in cycle T (IDLE), memory access in T+1, `resp_valid` in T+2. Throughput is one transaction per 3 cycles.
- Latency for an error: accepted in T, `resp_valid`+`resp_err` in T+1. The memory is never touched.
- Next acceptance is possible no earlier than the cycle after RESP. `req_ready` is never high outside IDLE.
- Simultaneous requests: only one `req_ready` bit is high in any cycle. The loser sees `req_ready`=0 and keeps waiting; it is served next.
- Reset mid-operation:
  - All outputs clear immediately, since control outputs are decoded from registered state.
  - A `reset_n` falling before the negative edge of ACCESS suppresses the store.
  - An in-flight response is dropped with no `resp_valid`.
- `mem_*` outputs are glitch-free within ACCESS; all are decoded from registers only.

## Structure
- Package `dmem_arb_pkg`:
  - State enum `dmem_arb_state_e` {IDLE, ACCESS, RESP}.
  - Funct3 constants `F3_B`=000, `F3_H`=001, `F3_W`=010, `F3_BU`=100.
  - `N_REQ`=2.
  - Legality function `dmem_access_legal(write, funct3, addr_lo)`.
- Sub-module `dmem_rr_pick`: combinational 2-way round-robin pick from `req_valid` and `last_q`, producing a one-hot grant.
- Top level holds the FSM, the request latch, `rdata_q` and `err_q`.

## Test plan
- **Word store/load:** req0 SW addr=0x010, wdata=0xDEADBEEF. Expect `mem_write`=1 for one cycle, `resp_valid`=01 at T+2. Then req0 LW 0x010 gives `resp_rdata`=0xDEADBEEF, `resp_err`=0.
- **Byte ops:** req1 SB addr=0x013, wdata=0x80. Expect `mem_funct3`=000, `mem_addr`=0x013. Then LB 0x013 gives 0xFFFFFF80 and LBU 0x013 gives 0x00000080, each on `resp_valid`=10.
- **Contention:** both valid every cycle with legal loads. Grants alternate 01, 10, 01, 10; the first grant is 01 after reset; no cycle has both `req_ready` bits set.
- **Misaligned:** req0 LW addr=0x002 gives `resp_valid`=01 and `resp_err`=1 at T+1 with `resp_rdata`=0. SH addr=0x005 and funct3=101 loads are rejected the same way. `mem_read`/`mem_write` stay 0 throughout.
- **Reset abort:** assert `reset_n`=0 during ACCESS of SW 0x020 with data 0x12345678, before the falling edge. Outputs go to 0 at once; a later LW 0x020 returns the old contents.
- **Withdrawal:** req1 valid for one cycle while req0 is being served, then dropped. Expect no grant or response for req1, and `last_q` unchanged by it.
